// File: rtl/aes_iter_core.sv
// ---------------------------------------------------------------------------
// aes_iter_core
//   Iterative AES encryption core: one full cipher round per clock, round
//   keys expanded on the fly (no stored key schedule).
//
//   Parameters
//     KEY_BITS         128 or 256 (NR = 10 or 14); anything else fails
//                      elaboration.
//     RESET_DONE_HOLD  1: o_valid held until i_ready; 0: o_valid lasts one
//                      cycle whatever i_ready does.
//
//   Ports
//     i_clock      clock, rising edge
//     i_rst_n      synchronous active-low reset
//     i_valid      plaintext block and key present
//     o_ready      core is idle and will accept a block
//     i_plain      128-bit plaintext
//     i_key        KEY_BITS cipher key
//     o_valid      o_cipher holds a completed result
//     i_ready      downstream takes o_cipher
//     o_cipher     128-bit ciphertext
//     i_abort      (AES_ABORT_EN only) drop the block in flight
//     o_dbg_state  current FSM state (0 IDLE, 1 ROUND, 2 DONE)
//
//   Byte order: FIPS-197 bit 0 (MSB of byte 0) is vector bit 127, so a hex
//   literal reads in FIPS byte order (byte 0 in [127:120]). For the key,
//   FIPS key bits 0..127 are i_key[KEY_BITS-1 -: 128].
//
//   Optional feature: define AES_ABORT_EN to add the i_abort port.
// ---------------------------------------------------------------------------
module aes_iter_core #(
    parameter int KEY_BITS        = 128,
    parameter int RESET_DONE_HOLD = 1
) (
    input  logic                i_clock,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [127:0]        i_plain,
    input  logic [KEY_BITS-1:0] i_key,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [127:0]        o_cipher,
`ifdef AES_ABORT_EN
    input  logic                i_abort,
`endif
    output logic [1:0]          o_dbg_state
);

    localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // S-box table, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Rcon for the key-schedule step that this round performs.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_step128(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n [4];
        n[0] = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n[1] = k[95:64] ^ n[0];
        n[2] = k[63:32] ^ n[1];
        n[3] = k[31:0]  ^ n[2];
        return {n[0], n[1], n[2], n[3]};
    endfunction

    // Eight new words: RotWord+SubWord+Rcon on the first, SubWord only on
    // the fifth, plain chaining elsewhere.
    function automatic logic [255:0] key_step256(input logic [255:0] k, input logic [7:0] rc);
        logic [31:0] w [8];
        logic [31:0] n [8];
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32 * i -: 32];
        n[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {rc, 24'h0};
        for (int i = 1; i < 8; i++) n[i] = (i == 4) ? (w[4] ^ sub_word(n[3])) : (w[i] ^ n[i-1]);
        return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
    endfunction

    // One complete round; MixColumns is skipped on the final round.
    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   s [16];
        logic [7:0]   a [4];
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127 - 8 * i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4 * c + r] = b[4 * ((c + r) % 4) + r];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[4 * c + r];
            if (last) begin
                for (int r = 0; r < 4; r++) o[127 - 8 * (4 * c + r) -: 8] = a[r];
            end else begin
                o[127 - 32 * c      -: 8] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
                o[127 - 32 * c - 8  -: 8] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
                o[127 - 32 * c - 16 -: 8] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
                o[127 - 32 * c - 24 -: 8] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
            end
        end
        return o ^ rk;
    endfunction

    state_t              r_state;
    logic                r_ready;
    logic                r_valid;
    logic [3:0]          r_round;
    logic [127:0]        r_blk;
    logic [127:0]        r_cipher;
    logic [KEY_BITS-1:0] r_key;

    logic [KEY_BITS-1:0] w_next_key;
    logic [127:0]        w_round_key;
    logic [127:0]        w_round_out;
    logic                w_abort;

`ifdef AES_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    generate
        if (KEY_BITS == 128) begin : g_k128
            assign w_next_key  = key_step128(r_key, rcon_of(r_round));
            assign w_round_key = w_next_key;
        end else if (KEY_BITS == 256) begin : g_k256
            // Odd rounds reuse the upper four stored words; even rounds
            // generate a fresh group of eight.
            logic [255:0] w_gen;
            assign w_gen       = key_step256(r_key, rcon_of({1'b0, r_round[3:1]}));
            assign w_next_key  = r_round[0] ? r_key : w_gen;
            assign w_round_key = r_round[0] ? r_key[127:0] : w_gen[255:128];
        end else begin : g_bad_key_bits
            $error("aes_iter_core: KEY_BITS must be 128 or 256");
        end
    endgenerate

    assign w_round_out = aes_round(r_blk, w_round_key, r_round == NR);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. The input side is ready only in IDLE; on the output
    // side o_valid/o_cipher stay put until i_ready (when held).
    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_round  <= '0;
            r_blk    <= '0;
            r_cipher <= '0;
            r_key    <= '0;
        end else if (w_abort && r_state != S_IDLE) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_round <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid && r_ready) begin
                        r_blk   <= i_plain ^ i_key[KEY_BITS-1 -: 128];
                        r_key   <= i_key;
                        r_round <= 4'd1;
                        r_ready <= 1'b0;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_blk <= w_round_out;
                    r_key <= w_next_key;
                    if (r_round == NR) begin
                        r_cipher <= w_round_out;
                        r_valid  <= 1'b1;
                        r_round  <= '0;
                        r_state  <= S_DONE;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                S_DONE: begin
                    if (i_ready || RESET_DONE_HOLD == 0) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready     = r_ready;
    assign o_valid     = r_valid;
    assign o_cipher    = r_cipher;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aes_iter_core.sv
// ---------------------------------------------------------------------------
// tb_aes_iter_core
//   Two cores (KEY_BITS 128 and 256) driven side by side. The reference is a
//   textbook AES (full key schedule, S-box built from the GF(2^8) inverse
//   and affine map) plus a cycle-level timing model of the block lifecycle.
// ---------------------------------------------------------------------------
module tb_aes_iter_core;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         ready;
    logic         valid_a, valid_b;
    logic [127:0] plain;
    logic [127:0] key_a;
    logic [255:0] key_b;
    logic         o_ready_a, o_valid_a, o_ready_b, o_valid_b;
    logic [127:0] o_cipher_a, o_cipher_b;
    logic [1:0]   dbg_a, dbg_b;
`ifdef AES_ABORT_EN
    logic         abort;
`endif

    aes_iter_core #(.KEY_BITS(128), .RESET_DONE_HOLD(1)) u_dut_a (
        .i_clock(clk), .i_rst_n(rst_n), .i_valid(valid_a), .o_ready(o_ready_a),
        .i_plain(plain), .i_key(key_a), .o_valid(o_valid_a), .i_ready(ready),
        .o_cipher(o_cipher_a),
`ifdef AES_ABORT_EN
        .i_abort(abort),
`endif
        .o_dbg_state(dbg_a)
    );

    aes_iter_core #(.KEY_BITS(256), .RESET_DONE_HOLD(1)) u_dut_b (
        .i_clock(clk), .i_rst_n(rst_n), .i_valid(valid_b), .o_ready(o_ready_b),
        .i_plain(plain), .i_key(key_b), .o_valid(o_valid_b), .i_ready(ready),
        .o_cipher(o_cipher_b),
`ifdef AES_ABORT_EN
        .i_abort(abort),
`endif
        .o_dbg_state(dbg_b)
    );

    localparam logic [127:0] P029 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K029 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C029 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P030 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K030 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C030 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K031 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C031 = 128'h8ea2b7ca516745bfeafc49904b496089;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference AES ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, xb, yb;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                yb = y[7:0];
                if (gf_mul(xb, yb) == 8'h01) inv = yb;
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // key[255 -: 32*nk] holds the cipher key; nk = 4 or 8 words
    function automatic logic [127:0] model_aes(input logic [127:0] pt, input logic [255:0] key, input int nk);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gf_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[4 * c + row] = s[4 * ((c + row) % 4) + row];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    if (r < nr)
                        s[4 * c + row] = gf_mul(t[4 * c + row], 8'h02) ^ gf_mul(t[4 * c + (row + 1) % 4], 8'h03)
                                       ^ t[4 * c + (row + 2) % 4] ^ t[4 * c + (row + 3) % 4];
                    else
                        s[4 * c + row] = t[4 * c + row];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- timing model + scoreboard ----------------
    logic [127:0] exp_q_a[$];
    logic [127:0] exp_q_b[$];
    bit           m_busy [2];
    bit           m_outv [2];
    int           m_age  [2];
    logic [127:0] m_cipher [2];
    bit           m_init = 1'b0;

    task automatic model_step(input int d, input bit v, input logic [127:0] pt, input logic [255:0] k, input bit ab);
        int nr;
        nr = (d == 0) ? 10 : 14;
        if (!rst_n) begin
            m_busy[d] = 1'b0; m_outv[d] = 1'b0; m_cipher[d] = '0;
            if (d == 0) exp_q_a.delete(); else exp_q_b.delete();
        end else if (ab && (m_busy[d] || m_outv[d])) begin
            if (m_busy[d]) begin
                if (d == 0) void'(exp_q_a.pop_front()); else void'(exp_q_b.pop_front());
            end
            m_busy[d] = 1'b0; m_outv[d] = 1'b0;
        end else if (m_outv[d]) begin
            if (ready) m_outv[d] = 1'b0;
        end else if (m_busy[d]) begin
            m_age[d]++;
            if (m_age[d] == nr) begin
                m_busy[d] = 1'b0;
                m_outv[d] = 1'b1;
                m_cipher[d] = (d == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
            end
        end else if (v) begin
            m_busy[d] = 1'b1;
            m_age[d]  = 0;
            if (d == 0) exp_q_a.push_back(model_aes(pt, k, 4));
            else        exp_q_b.push_back(model_aes(pt, k, 8));
        end
    endtask

    always @(posedge clk) begin
        bit ab;
`ifdef AES_ABORT_EN
        ab = abort;
`else
        ab = 1'b0;
`endif
        model_step(0, valid_a, plain, {key_a, 128'h0}, ab);
        model_step(1, valid_b, plain, key_b, ab);
        if (!rst_n) m_init = 1'b1;
    end

    // compare process: every cycle once reset has been applied
    always @(negedge clk) begin
        if (m_init) begin
            check("ready_a",  {127'h0, o_ready_a}, {127'h0, !(m_busy[0] || m_outv[0])});
            check("valid_a",  {127'h0, o_valid_a}, {127'h0, m_outv[0]});
            check("cipher_a", o_cipher_a, m_cipher[0]);
            check("ready_b",  {127'h0, o_ready_b}, {127'h0, !(m_busy[1] || m_outv[1])});
            check("valid_b",  {127'h0, o_valid_b}, {127'h0, m_outv[1]});
            check("cipher_b", o_cipher_b, m_cipher[1]);
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic send_a(input logic [127:0] p, input logic [127:0] k);
        valid_a = 1'b1; plain = p; key_a = k;
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [127:0] p, input logic [255:0] k);
        valid_b = 1'b1; plain = p; key_b = k;
        @(negedge clk);
        valid_b = 1'b0;
    endtask

    // returns the latency in the T+n sense, accept cycle = T
    task automatic wait_valid(input int d, output int lat);
        int j;
        j = 0;
        while (((d == 0) ? o_valid_a : o_valid_b) !== 1'b1 && j < 40) begin
            @(negedge clk);
            j++;
        end
        lat = j + 1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        bit seen;
        rst_n = 1'b0; ready = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
        plain = '0; key_a = '0; key_b = '0;
`ifdef AES_ABORT_EN
        abort = 1'b0;
`endif
        build_sbox();

        // pin the reference itself
        check("model_sbox_00", {120'h0, sbox_t[0]}, 128'h63);
        check("model_sbox_53", {120'h0, sbox_t[8'h53]}, 128'hed);
        check("model_kat029", model_aes(P029, {K029, 128'h0}, 4), C029);
        check("model_kat030", model_aes(P030, {K030, 128'h0}, 4), C030);
        check("model_kat031", model_aes(P030, K031, 8), C031);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_a",  {127'h0, o_ready_a}, 128'h1);
        check("rst_valid_a",  {127'h0, o_valid_a}, 128'h0);
        check("rst_cipher_a", o_cipher_a, 128'h0);
        check("rst_ready_b",  {127'h0, o_ready_b}, 128'h1);

        // FIPS-197 appendix B vector, i_ready high
        send_a(P029, K029);
        wait_valid(0, lat);
        check("lat_029", 128'(lat), 128'd11);
        check("kat_029", o_cipher_a, C029);
        @(negedge clk);
        check("hs_029_valid", {127'h0, o_valid_a}, 128'h0);
        check("hs_029_ready", {127'h0, o_ready_a}, 128'h1);

        // output stall: 5 cycles of i_ready low with extra i_valid
        ready = 1'b0;
        send_a(P030, K030);
        wait_valid(0, lat);
        check("lat_030", 128'(lat), 128'd11);
        check("kat_030", o_cipher_a, C030);
        valid_a = 1'b1; plain = {$urandom(), $urandom(), $urandom(), $urandom()}; key_a = ~K030;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid",  {127'h0, o_valid_a}, 128'h1);
            check("stall_ready",  {127'h0, o_ready_a}, 128'h0);
            check("stall_cipher", o_cipher_a, C030);
        end
        valid_a = 1'b0; ready = 1'b1;
        @(negedge clk);
        check("stall_rel_valid", {127'h0, o_valid_a}, 128'h0);
        check("stall_rel_ready", {127'h0, o_ready_a}, 128'h1);

        // 256-bit key vector
        send_b(P030, K031);
        wait_valid(1, lat);
        check("lat_031", 128'(lat), 128'd15);
        check("kat_031", o_cipher_b, C031);
        @(negedge clk);

        // reset during round 5, with a concurrent i_valid
        send_a(P029, K029);
        repeat (4) @(negedge clk);
        rst_n = 1'b0; valid_a = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; valid_a = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_valid_a) seen = 1'b1;
        end
        check("rst_mid_no_valid", {127'h0, seen}, 128'h0);
        check("rst_mid_ready",    {127'h0, o_ready_a}, 128'h1);
        check("rst_mid_cipher",   o_cipher_a, 128'h0);
        send_a(P030, K030);
        wait_valid(0, lat);
        check("kat_030_after_rst", o_cipher_a, C030);
        @(negedge clk);

`ifdef AES_ABORT_EN
        // abort during round 3, then a back-to-back block
        send_a(P030, K030);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", {127'h0, o_ready_a}, 128'h1);
        check("abort_valid", {127'h0, o_valid_a}, 128'h0);
        check("abort_cipher", o_cipher_a, C030);
        send_a(P029, K029);
        wait_valid(0, lat);
        check("abort_lat_029", 128'(lat), 128'd11);
        check("kat_029_after_abort", o_cipher_a, C029);
        @(negedge clk);
`endif

        // randomized traffic, checked cycle by cycle against the model
        for (int cyc = 0; cyc < 2500; cyc++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            valid_a = ($urandom_range(0, 3) == 0);
            valid_b = ($urandom_range(0, 3) == 0);
            ready   = ($urandom_range(0, 2) != 0);
            plain   = {$urandom(), $urandom(), $urandom(), $urandom()};
            key_a   = {$urandom(), $urandom(), $urandom(), $urandom()};
            key_b   = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
`ifdef AES_ABORT_EN
            abort   = ($urandom_range(0, 59) == 0);
`endif
            @(negedge clk);
        end
        rst_n = 1'b1; valid_a = 1'b0; valid_b = 1'b0; ready = 1'b1;
`ifdef AES_ABORT_EN
        abort = 1'b0;
`endif
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 SHALL have parameter KEY_BITS, default 128, meaning cipher key length; legal values 128 or 256, giving round count NR = 10 or 14.
REQ-002 SHALL have parameter RESET_DONE_HOLD, default 1, meaning o_valid stays high until accepted (1) or drops after one cycle (0).
REQ-003 SHALL use a single clock; reset SHALL be synchronous and active-low.
REQ-004 i_clock  in  1  clock; all logic on rising edge.
REQ-005 i_rst_n  in  1  synchronous active-low reset.
REQ-006 i_valid  in  1  input block and key present.
REQ-007 o_ready  out  1  core can accept an input block.
REQ-008 i_plain  in  128  plaintext, bit 0 = MSB of byte 0.
REQ-009 i_key  in  KEY_BITS  cipher key, bit 0 = MSB of key byte 0.
REQ-010 o_valid  out  1  o_cipher holds a completed result.
REQ-011 i_ready  in  1  downstream accepts o_cipher.
REQ-012 o_cipher  out  128  ciphertext, same byte order as i_plain.

Function
REQ-013 FSM states SHALL be IDLE, ROUND, DONE; IDLE->ROUND on i_valid&&o_ready; ROUND->DONE after round NR; DONE->IDLE on handshake (RESET_DONE_HOLD=1) or after one cycle (RESET_DONE_HOLD=0).
REQ-014 o_ready SHALL be 1 only in IDLE.
REQ-015 On accept (cycle T), state <= i_plain XOR i_key[0:127]; key register <= i_key; round counter <= 1.
REQ-016 Each ROUND cycle SHALL perform one full FIPS-197 round: SubBytes, ShiftRows, MixColumns (omitted when counter == NR), AddRoundKey.
REQ-017 Round keys SHALL be expanded on the fly per FIPS-197, one round key per ROUND cycle, Rcon from a counter-indexed table; no full key-schedule storage.
REQ-018 For KEY_BITS=256, the key register SHALL hold 8 words; odd rounds use the stored upper 4 words, even rounds generate 8 new words (RotWord+SubWord+Rcon on first word, SubWord only on fifth word).
REQ-019 Latency: o_valid SHALL rise in cycle T+NR+1 (11 for 128, 15 for 256).
REQ-020 o_cipher SHALL be stable while o_valid=1 and SHALL NOT change until the output handshake completes.
REQ-021 i_valid in ROUND or DONE SHALL be ignored; i_plain/i_key are sampled only at accept.
REQ-022 In DONE with o_valid && i_ready, the core SHALL return to IDLE next cycle; a new block can be accepted no earlier than the cycle after that.
REQ-023 Round counter width SHALL be 4 bits; the counter SHALL never exceed NR.
REQ-024 An illegal KEY_BITS SHALL be a compile/elaboration error.

Reset
REQ-025 While i_rst_n=0 at a rising edge: FSM <= IDLE, o_valid <= 0, o_ready <= 1 after release, o_cipher <= 0, counter <= 0, key register <= 0.
REQ-026 Reset mid-ROUND or in DONE SHALL discard the block with no o_valid pulse; i_valid concurrent with reset SHALL be ignored.

Configuration
REQ-027 Macro AES_ABORT_EN: when defined, SHALL add port i_abort (in, 1); i_abort=1 in ROUND or DONE returns the FSM to IDLE next cycle with o_valid=0 and o_cipher unchanged; i_abort in IDLE has no effect; reset overrides abort.
REQ-028 Without AES_ABORT_EN, port i_abort SHALL NOT exist and the only exits from ROUND/DONE are completion and reset.

Verification
REQ-029 KEY_BITS=128, plain 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, i_ready=1 -> o_cipher 3925841d02dc09fbdc118597196a0b32, o_valid at T+11.
REQ-030 KEY_BITS=128, plain 00112233445566778899aabbccddeeff, key 000102...0f -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-031 KEY_BITS=256, same plain, key 000102...1f -> 8ea2b7ca516745bfeafc49904b496089, o_valid at T+15.
REQ-032 i_ready=0 for 5 cycles after o_valid -> o_valid and o_cipher held, o_ready=0, extra i_valid ignored; i_ready=1 -> IDLE next cycle.
REQ-033 i_rst_n=0 for one cycle at round 5 -> o_valid never rises for that block, o_ready=1 after reset, next block (REQ-030 vector) correct.
REQ-034 With AES_ABORT_EN, i_abort at round 3 -> IDLE next cycle, no o_valid; back-to-back REQ-029 vector afterwards correct.
